// File: rtl/muldiv_hilo_ctrl_if.sv
// Request/result bundle between the control unit and the HI/LO multiply-divide sequencer.
interface muldiv_hilo_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hilo_read;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, hilo_read,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, hilo_read,
    output busy, done, stall, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// MIPS HI/LO owner: sequential shift-add multiply and restoring divide, plus MTHI/MTLO.
// One iteration per clock; WIDTH run cycles followed by one sign-fix cycle.
module muldiv_hilo_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_hilo_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned PRD_W = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_signed;
  logic             w_rs_neg;
  logic             w_rt_neg;
  logic [WIDTH-1:0] w_rs_mag;
  logic [WIDTH-1:0] w_rt_mag;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_trial;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [PRD_W-1:0] w_prod;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  // Operand magnitudes for signed ops; MULT and DIV have op[0]=0.
  always_comb begin
    w_signed = ~bus.op[0];
    w_rs_neg = w_signed & bus.rs_data[WIDTH-1];
    w_rt_neg = w_signed & bus.rt_data[WIDTH-1];
    w_rs_mag = w_rs_neg ? (-bus.rs_data) : bus.rs_data;
    w_rt_mag = w_rt_neg ? (-bus.rt_data) : bus.rt_data;
  end

  // One iteration: acc_hi/acc_lo hold {product hi, multiplier} or {remainder, quotient}.
  always_comb begin
    w_sum     = SUM_W'(r_acc_hi) + (r_acc_lo[0] ? SUM_W'(r_opnd) : SUM_W'(0));
    w_trial   = {r_acc_hi, r_acc_lo[WIDTH-1]} - SUM_W'(r_opnd);
    w_step_hi = w_sum[WIDTH:1];
    w_step_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
    if (r_is_div) begin
      if (!w_trial[WIDTH]) begin
        w_step_hi = w_trial[WIDTH-1:0];
        w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_step_hi = {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
        w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix applied on the FIX edge.
  always_comb begin
    w_prod   = r_sign_q ? (-{r_acc_hi, r_acc_lo}) : {r_acc_hi, r_acc_lo};
    w_fix_hi = w_prod[PRD_W-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_fix_hi = r_sign_r ? (-r_acc_hi) : r_acc_hi;
      w_fix_lo = r_sign_q ? (-r_acc_lo) : r_acc_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_opnd   <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MTHI: r_hi <= bus.rs_data;
              OP_MTLO: r_lo <= bus.rs_data;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_is_div <= bus.op[1];
                r_sign_q <= w_rs_neg ^ w_rt_neg;
                r_sign_r <= w_rs_neg;
                r_opnd   <= bus.op[1] ? w_rt_mag : w_rs_mag;
                r_acc_hi <= '0;
                r_acc_lo <= bus.op[1] ? w_rs_mag : w_rt_mag;
                r_cnt    <= '0;
                r_state  <= S_RUN;
                r_busy   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.stall = bus.hilo_read & r_busy;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: per-scenario tasks with hand-computed HI/LO results.
module tb_muldiv_hilo_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  muldiv_hilo_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_hilo_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; returns at the falling edge of the first non-busy cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int busy_cnt, output int stall_cnt,
                        output logic done_seen, output logic stall_done);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt  = 0;
    stall_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) break;
      busy_cnt++;
      if (bus.stall) stall_cnt++;
      @(negedge clk);
    end
    done_seen  = bus.done;
    stall_done = bus.stall;
  endtask

  task automatic test_reset();
    checks += 5;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
  endtask

  task automatic test_multu();
    int b, s; logic d, sd;
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, b, s, d, sd);
    checks += 4;
    if (b !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d exp 33", b); end
    if (d !== 1'b1) begin errors++; $display("FAIL multu_done got %b exp 1", d); end
    if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", bus.hi); end
    if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", bus.lo); end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b exp 0", bus.done); end
  endtask

  task automatic test_mult();
    int b, s; logic d, sd;
    run_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0007, b, s, d, sd);
    checks += 2;
    if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg3x7_hi got %h exp ffffffff", bus.hi); end
    if (bus.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg3x7_lo got %h exp ffffffeb", bus.lo); end
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, b, s, d, sd);
    checks += 2;
    if (bus.hi !== 32'h4000_0000) begin errors++; $display("FAIL mult_minsq_hi got %h exp 40000000", bus.hi); end
    if (bus.lo !== 32'h0000_0000) begin errors++; $display("FAIL mult_minsq_lo got %h exp 0", bus.lo); end
    run_op(3'b000, 32'h0000_0005, 32'hFFFF_FFFC, b, s, d, sd);
    checks += 2;
    if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_5xneg4_hi got %h exp ffffffff", bus.hi); end
    if (bus.lo !== 32'hFFFF_FFEC) begin errors++; $display("FAIL mult_5xneg4_lo got %h exp ffffffec", bus.lo); end
  endtask

  task automatic test_div();
    int b, s; logic d, sd;
    run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, b, s, d, sd);
    checks += 3;
    if (b !== 33) begin errors++; $display("FAIL div_busy_cycles got %0d exp 33", b); end
    if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg7_2_lo got %h exp fffffffd", bus.lo); end
    if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg7_2_hi got %h exp ffffffff", bus.hi); end
    run_op(3'b011, 32'h0000_0007, 32'h0000_0002, b, s, d, sd);
    checks += 2;
    if (bus.lo !== 32'h0000_0003) begin errors++; $display("FAIL divu_7_2_lo got %h exp 3", bus.lo); end
    if (bus.hi !== 32'h0000_0001) begin errors++; $display("FAIL divu_7_2_hi got %h exp 1", bus.hi); end
    run_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, b, s, d, sd);
    checks += 2;
    if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_neg2_lo got %h exp fffffffd", bus.lo); end
    if (bus.hi !== 32'h0000_0001) begin errors++; $display("FAIL div_7_neg2_hi got %h exp 1", bus.hi); end
  endtask

  task automatic test_div_corner();
    int b, s; logic d, sd;
    run_op(3'b011, 32'h0000_1234, 32'h0000_0000, b, s, d, sd);
    checks += 4;
    if (b !== 33) begin errors++; $display("FAIL divz_busy_cycles got %0d exp 33", b); end
    if (d !== 1'b1) begin errors++; $display("FAIL divz_done got %b exp 1", d); end
    if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo got %h exp ffffffff", bus.lo); end
    if (bus.hi !== 32'h0000_1234) begin errors++; $display("FAIL divz_hi got %h exp 1234", bus.hi); end
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, b, s, d, sd);
    checks += 2;
    if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_min_m1_lo got %h exp 80000000", bus.lo); end
    if (bus.hi !== 32'h0000_0000) begin errors++; $display("FAIL div_min_m1_hi got %h exp 0", bus.hi); end
  endtask

  task automatic test_stall();
    int b, s; logic d, sd;
    bus.hilo_read = 1'b1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall_idle got %b exp 0", bus.stall); end
    run_op(3'b001, 32'h0000_0003, 32'h0000_0004, b, s, d, sd);
    checks += 4;
    if (s !== 33) begin errors++; $display("FAIL stall_cycles got %0d exp 33", s); end
    if (sd !== 1'b0) begin errors++; $display("FAIL stall_done_cycle got %b exp 0", sd); end
    if (d !== 1'b1) begin errors++; $display("FAIL stall_done got %b exp 1", d); end
    if (bus.lo !== 32'h0000_000C) begin errors++; $display("FAIL stall_lo got %h exp c", bus.lo); end
    bus.hilo_read = 1'b0;
  endtask

  task automatic test_mthi_mtlo();
    bus.start = 1'b1; bus.op = 3'b100; bus.rs_data = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b101; bus.rs_data = 32'h5A5A_0001;
    checks += 3;
    if (bus.hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_hi got %h exp a5a5a5a5", bus.hi); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL mthi_done got %b exp 0", bus.done); end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b110; bus.rs_data = 32'hDEAD_BEEF; bus.rt_data = 32'h1;
    checks += 2;
    if (bus.lo !== 32'h5A5A_0001) begin errors++; $display("FAIL mtlo_lo got %h exp 5a5a0001", bus.lo); end
    if (bus.hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mtlo_hi_kept got %h exp a5a5a5a5", bus.hi); end
    @(negedge clk);
    bus.start = 1'b0;
    checks += 3;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL badop_busy got %b exp 0", bus.busy); end
    if (bus.hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL badop_hi got %h exp a5a5a5a5", bus.hi); end
    if (bus.lo !== 32'h5A5A_0001) begin errors++; $display("FAIL badop_lo got %h exp 5a5a0001", bus.lo); end
  endtask

  task automatic test_busy_ignore();
    int b;
    bus.start = 1'b1; bus.op = 3'b001; bus.rs_data = 32'h3; bus.rt_data = 32'h5;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b100; bus.rs_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b011; bus.rs_data = 32'h64; bus.rt_data = 32'h7;
    checks += 2;
    if (bus.hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL busy_mthi_hi got %h exp a5a5a5a5", bus.hi); end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_mthi_busy got %b exp 1", bus.busy); end
    @(negedge clk);
    bus.start = 1'b0;
    b = 2;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) break;
      checks++;
      if (bus.hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL busy_hi_stable got %h exp a5a5a5a5", bus.hi); end
      b++;
      @(negedge clk);
    end
    checks += 4;
    if (b !== 33) begin errors++; $display("FAIL busy_ignore_cycles got %0d exp 33", b); end
    if (bus.done !== 1'b1) begin errors++; $display("FAIL busy_ignore_done got %b exp 1", bus.done); end
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL busy_ignore_hi got %h exp 0", bus.hi); end
    if (bus.lo !== 32'hF) begin errors++; $display("FAIL busy_ignore_lo got %h exp f", bus.lo); end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_no_queue got %b exp 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int b, s; logic d, sd;
    run_op(3'b001, 32'h0001_0000, 32'h0001_0000, b, s, d, sd);
    checks += 3;
    if (d !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b exp 1", d); end
    if (bus.hi !== 32'h1) begin errors++; $display("FAIL b2b_first_hi got %h exp 1", bus.hi); end
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL b2b_first_lo got %h exp 0", bus.lo); end
    run_op(3'b011, 32'd100, 32'd7, b, s, d, sd);
    checks += 4;
    if (b !== 33) begin errors++; $display("FAIL b2b_second_busy got %0d exp 33", b); end
    if (d !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b exp 1", d); end
    if (bus.lo !== 32'd14) begin errors++; $display("FAIL b2b_second_lo got %h exp e", bus.lo); end
    if (bus.hi !== 32'd2) begin errors++; $display("FAIL b2b_second_hi got %h exp 2", bus.hi); end
  endtask

  task automatic test_reset_mid();
    int b, s, dcnt; logic d, sd;
    bus.start = 1'b1; bus.op = 3'b011; bus.rs_data = 32'h00FF_0000; bus.rt_data = 32'h3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks += 4;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", bus.done); end
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi got %h exp 0", bus.hi); end
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo got %h exp 0", bus.lo); end
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    checks++;
    if (dcnt !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d exp 0", dcnt); end
    run_op(3'b011, 32'd100, 32'd7, b, s, d, sd);
    checks += 4;
    if (b !== 33) begin errors++; $display("FAIL rstmid_after_busy got %0d exp 33", b); end
    if (d !== 1'b1) begin errors++; $display("FAIL rstmid_after_done got %b exp 1", d); end
    if (bus.lo !== 32'd14) begin errors++; $display("FAIL rstmid_after_lo got %h exp e", bus.lo); end
    if (bus.hi !== 32'd2) begin errors++; $display("FAIL rstmid_after_hi got %h exp 2", bus.hi); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op        = 3'b000;
    bus.rs_data   = '0;
    bus.rt_data   = '0;
    bus.hilo_read = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    reset         = 1'b0;
    bus.hilo_read = 1'b0;
    @(negedge clk);
    test_multu();
    test_mult();
    test_div();
    test_div_corner();
    test_stall();
    test_mthi_mtlo();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
